// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller.
// States, opcode/funct values, datapath select codes, instruction class bundle.
package mc_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_OR   = 3'd2;
   localparam logic [2:0] ALU_LUI  = 3'd3;

   localparam logic [1:0] DST_RT   = 2'd0;
   localparam logic [1:0] DST_RD   = 2'd1;
   localparam logic [1:0] DST_RA   = 2'd2;

   localparam logic [1:0] WB_ALU   = 2'd0;
   localparam logic [1:0] WB_MEM   = 2'd1;
   localparam logic [1:0] WB_PC4   = 2'd2;

   typedef struct packed {
      logic addu;
      logic subu;
      logic ori;
      logic lw;
      logic sw;
      logic beq;
      logic lui;
      logic j;
      logic jal;
      logic jr;
   } ins_t;

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath/memory bundle.
// master = controller side, slave = datapath/memory side.
interface mc_if #(
   parameter int RETIRE_W = 32
);
   logic [5:0]          opcode;
   logic [5:0]          funct;
   logic                imem_rdy;
   logic                dmem_rdy;
   logic                pc_en;
   logic                ir_we;
   logic                nPC_sel;
   logic                j;
   logic                jal;
   logic                jr;
   logic                reg_we;
   logic [1:0]          reg_dst;
   logic                alu_src;
   logic                ext_op;
   logic [2:0]          alu_op;
   logic [1:0]          mem_to_reg;
   logic                dmem_req;
   logic                dmem_we;
   logic                illegal;
   logic [2:0]          state_o;
   logic [RETIRE_W-1:0] retired;

   modport master (
      input  opcode, funct, imem_rdy, dmem_rdy,
      output pc_en, ir_we, nPC_sel, j, jal, jr,
      output reg_we, reg_dst, alu_src, ext_op,
      output alu_op, mem_to_reg, dmem_req, dmem_we,
      output illegal, state_o, retired
   );

   modport slave (
      output opcode, funct, imem_rdy, dmem_rdy,
      input  pc_en, ir_we, nPC_sel, j, jal, jr,
      input  reg_we, reg_dst, alu_src, ext_op,
      input  alu_op, mem_to_reg, dmem_req, dmem_we,
      input  illegal, state_o, retired
   );
endinterface

// File: rtl/mc_decode.sv
// Combinational opcode/funct decoder.
// Produces a one-hot instruction class; no match flags illegal.
module mc_decode
   import mc_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output ins_t       ins,
   output logic       illegal
);

   always_comb begin
      ins = '0;
      unique case (opcode)
         OP_RTYPE: begin
            unique case (funct)
               FN_ADDU: ins.addu = 1'b1;
               FN_SUBU: ins.subu = 1'b1;
               FN_JR:   ins.jr   = 1'b1;
               default: ;
            endcase
         end
         OP_ORI:  ins.ori = 1'b1;
         OP_LW:   ins.lw  = 1'b1;
         OP_SW:   ins.sw  = 1'b1;
         OP_BEQ:  ins.beq = 1'b1;
         OP_LUI:  ins.lui = 1'b1;
         OP_J:    ins.j   = 1'b1;
         OP_JAL:  ins.jal = 1'b1;
         default: ;
      endcase
   end

   assign illegal = (ins == '0);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the 10-instruction MIPS subset.
// One pc_en pulse per instruction, issued in its final state.
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int RETIRE_W = 32
) (
   input  logic clk,
   input  logic reset,
   mc_if.master bus
);

   state_t              state;
   state_t              state_n;
   ins_t                ins;
   logic                dec_ill;
   logic                done;
   logic                in_alu;
   logic [RETIRE_W-1:0] retired_q;

   mc_decode u_dec (
      .opcode  (bus.opcode),
      .funct   (bus.funct),
      .ins     (ins),
      .illegal (dec_ill)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_FETCH;
         retired_q <= '0;
      end else begin
         state <= state_n;
         if (done)
            retired_q <= retired_q + RETIRE_W'(1);
      end
   end

   assign bus.state_o = state;
   assign bus.retired = retired_q;

   // ALU selects stay stable from EXEC until the instruction leaves WB
   assign in_alu = (state == S_EXEC) ||
                   (state == S_MEM)  ||
                   (state == S_WB);

   always_comb begin
      bus.alu_op  = ALU_ADD;
      bus.alu_src = 1'b0;
      bus.ext_op  = 1'b0;
      if (in_alu) begin
         unique case (1'b1)
            ins.subu,
            ins.beq: bus.alu_op = ALU_SUB;
            ins.ori: begin
               bus.alu_op  = ALU_OR;
               bus.alu_src = 1'b1;
            end
            ins.lui: begin
               bus.alu_op  = ALU_LUI;
               bus.alu_src = 1'b1;
            end
            ins.lw,
            ins.sw: begin
               bus.alu_src = 1'b1;
               bus.ext_op  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_n        = state;
      done           = 1'b0;
      bus.pc_en      = 1'b0;
      bus.ir_we      = 1'b0;
      bus.nPC_sel    = 1'b0;
      bus.j          = 1'b0;
      bus.jal        = 1'b0;
      bus.jr         = 1'b0;
      bus.reg_we     = 1'b0;
      bus.reg_dst    = DST_RT;
      bus.mem_to_reg = WB_ALU;
      bus.dmem_req   = 1'b0;
      bus.dmem_we    = 1'b0;
      bus.illegal    = 1'b0;

      case (state)
         S_FETCH: begin
            if (bus.imem_rdy) begin
               bus.ir_we = 1'b1;
               state_n   = S_DECODE;
            end
         end
         S_DECODE: begin
            unique case (1'b1)
               dec_ill: begin
                  bus.illegal = 1'b1;
                  bus.pc_en   = 1'b1;
                  state_n     = S_FETCH;
               end
               ins.j: begin
                  bus.j = 1'b1;
                  done  = 1'b1;
               end
               ins.jal: begin
                  bus.jal        = 1'b1;
                  bus.reg_we     = 1'b1;
                  bus.reg_dst    = DST_RA;
                  bus.mem_to_reg = WB_PC4;
                  done           = 1'b1;
               end
               ins.jr: begin
                  bus.jr = 1'b1;
                  done   = 1'b1;
               end
               default: state_n = S_EXEC;
            endcase
         end
         S_EXEC: begin
            unique case (1'b1)
               ins.beq: begin
                  bus.nPC_sel = 1'b1;
                  done        = 1'b1;
               end
               ins.lw,
               ins.sw:  state_n = S_MEM;
               default: state_n = S_WB;
            endcase
         end
         S_MEM: begin
            bus.dmem_req = 1'b1;
            bus.dmem_we  = ins.sw;
            if (bus.dmem_rdy) begin
               if (ins.sw)
                  done = 1'b1;
               else
                  state_n = S_WB;
            end
         end
         S_WB: begin
            bus.reg_we = 1'b1;
            if (ins.addu || ins.subu)
               bus.reg_dst = DST_RD;
            if (ins.lw)
               bus.mem_to_reg = WB_MEM;
            done = 1'b1;
         end
         default: state_n = S_FETCH;
      endcase

      if (done) begin
         bus.pc_en = 1'b1;
         state_n   = S_FETCH;
      end

      // Reset wins combinationally so an abandoned instruction writes nothing
      if (reset) begin
         done         = 1'b0;
         state_n      = S_FETCH;
         bus.pc_en    = 1'b0;
         bus.ir_we    = 1'b0;
         bus.nPC_sel  = 1'b0;
         bus.j        = 1'b0;
         bus.jal      = 1'b0;
         bus.jr       = 1'b0;
         bus.reg_we   = 1'b0;
         bus.dmem_req = 1'b0;
         bus.dmem_we  = 1'b0;
         bus.illegal  = 1'b0;
      end
   end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control FSM that sequences the instruction fetch unit and the rest of the datapath for the 10-instruction MIPS subset: addu, subu, ori, lw, sw, beq, lui, j, jal, jr. It raises the fetch unit's pc_en exactly once per instruction, in that instruction's final state, and drives nPC_sel/j/jal/jr at the same time. It also handshakes with instruction and data memory and counts retired instructions.

Parameters:
RETIRE_W, 32, width of the retired-instruction counter (wraps).

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
imem_rdy  in  1  instruction word valid this cycle
dmem_rdy  in  1  data access completes this cycle
pc_en  out  1  PC update strobe to fetch unit
ir_we  out  1  latch instruction register
nPC_sel  out  1  branch select (beq); fetch unit qualifies it with Zero
j  out  1  jump select
jal  out  1  jump-and-link select
jr  out  1  jump-register select
reg_we  out  1  register file write
reg_dst  out  2  0=rt, 1=rd, 2=$31
alu_src  out  1  0=reg, 1=imm
ext_op  out  1  0=zero-ext, 1=sign-ext
alu_op  out  3  0=ADD, 1=SUB, 2=OR, 3=LUI
mem_to_reg  out  2  0=ALU, 1=mem, 2=PC+4
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (only with dmem_req)
illegal  out  1  one-cycle pulse on undecodable instruction
state_o  out  3  current state encoding
retired  out  RETIRE_W  count of completed instructions

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5-7 are unreachable and go to FETCH.
- Reset is checked at the clock edge: state<=FETCH, retired<=0. While reset=1, all strobes are forced to 0 combinationally (pc_en, ir_we, reg_we, dmem_req, dmem_we, illegal, nPC_sel, j, jal, jr). A reset in any state, including mid-MEM, abandons the instruction and leaves no partial writes.
- Decode: opcode 000000 with funct 100001=addu, 100011=subu, 001000=jr; opcode 001101=ori, 100011=lw, 101011=sw, 000100=beq, 001111=lui, 000010=j, 000011=jal. Anything else is illegal.
- "Completes" means pc_en=1 in that cycle, next state FETCH, and retired increments by 1.
- FETCH: wait while imem_rdy=0. When imem_rdy=1, ir_we=1 and go to DECODE.
- DECODE:
  - j: j=1, completes.
  - jal: jal=1, reg_we=1, reg_dst=2, mem_to_reg=2, completes.
  - jr: jr=1, completes.
  - illegal: illegal=1, pc_en=1, go to FETCH; retired does not increment.
  - Any other instruction: go to EXEC.
- EXEC (alu_op/alu_src/ext_op are held from EXEC through MEM/WB for the current instruction):
  - beq: alu_op=SUB, nPC_sel=1, completes.
  - addu/subu: alu_op ADD/SUB, alu_src=0, go to WB.
  - ori: alu_op OR, alu_src=1, ext_op=0, go to WB.
  - lui: alu_op LUI, alu_src=1, go to WB.
  - lw/sw: alu_op ADD, alu_src=1, ext_op=1, go to MEM.
- MEM: dmem_req=1, and dmem_we=1 for sw. Stay in MEM while dmem_rdy=0. On dmem_rdy=1: sw completes; lw goes to WB.
- WB: reg_we=1, then completes.
  - reg_dst: 1 for R-type, 0 for ori/lui/lw.
  - mem_to_reg: 1 for lw, else 0.
- All strobes are 0 in any state or condition not listed above.
- pc_en is high for exactly one cycle per instruction, and never in FETCH, so the fetch unit computes npc/branch targets from the PC of the instruction in flight.
- retired wraps from all-ones to 0.
- Latency with rdy signals tied high: j/jal/jr/illegal 2 cycles; beq 3; R-type/ori/lui/sw 4; lw 5.

Decomposition:
- Shared package mc_pkg holds:
  - state encodings
  - opcode/funct constants
  - alu_op, reg_dst and mem_to_reg encodings
- Sub-module mc_decode: purely combinational opcode/funct to one-hot instruction class plus illegal flag. The FSM stays in mc_ctrl.

Test Plan:
- addu, rdy signals tied 1, after reset: states 0,1,2,4,0. pc_en is high only in WB (cycle 4); reg_we=1 with reg_dst=1; retired=1.
- lw, with dmem_rdy held 0 for 3 MEM cycles: dmem_req=1 and dmem_we=0 for 4 cycles, then WB with mem_to_reg=1 and reg_we=1. Total 8 cycles; pc_en pulses once.
- sw, imem_rdy=0 for 2 cycles in FETCH: ir_we is delayed 2 cycles; MEM asserts dmem_we=1 with dmem_req; completes from MEM with no reg_we.
- jal (000011) then jr (000000/001000): each completes in DECODE. jal gives jal=1, reg_dst=2, mem_to_reg=2; jr gives jr=1. retired advances 0→2 after 4 cycles.
- Illegal opcode 111111: illegal=1 and pc_en=1 in DECODE; retired unchanged; next state FETCH.
- reset=1 asserted while in MEM with dmem_req=1: dmem_req and dmem_we drop to 0 in that same cycle; next state FETCH; retired=0.
